mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_pkg.sv | 33 +++
 rtl/mem_access_ctrl_if.sv | 36 +++
 rtl/mem_lane_align.sv | 61 ++++++
 rtl/mem_access_ctrl.sv | 120 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// mem_pkg -- shared definitions for the mem_access_ctrl slice.
// Size encodings, request op layout, FSM state type and default DRAM address width.
// Optional feature macro used by this slice: MEM_MISALIGN_CHECK_EN.
package mem_pkg;

   // DRAM word-address width (64 KB of 32-bit words)
   localparam int ADDR_W = 14;

   // Access size encodings; size 3 is treated as a word access
   localparam logic [1:0] MEM_B = 2'd0;
   localparam logic [1:0] MEM_H = 2'd1;
   localparam logic [1:0] MEM_W = 2'd2;

   // Request op as carried on req_op: {unsigned, size}
   typedef struct packed {
      logic       uns;
      logic [1:0] size;
   } mem_op_t;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   // Sizes 2 and 3 both mean a full word
   function automatic logic is_word(input logic [1:0] size);
      return size[1];
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if -- request/response handshake bundle of mem_access_ctrl.
// resp_err exists only when MEM_MISALIGN_CHECK_EN is defined.
interface mem_access_ctrl_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
`ifdef MEM_MISALIGN_CHECK_EN
   logic        resp_err;
`endif

   // Requester side
   modport master (
      output req_valid, req_we, req_op, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata
`ifdef MEM_MISALIGN_CHECK_EN
      , input resp_err
`endif
   );

   // Controller side
   modport slave (
      input  req_valid, req_we, req_op, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata
`ifdef MEM_MISALIGN_CHECK_EN
      , output resp_err
`endif
   );

endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align -- combinational byte/halfword lane handling.
// Merges store data into the old DRAM word and extends load lanes to 32 bits.
// Unaffected by MEM_MISALIGN_CHECK_EN.
module mem_lane_align
   import mem_pkg::*;
(
   input  mem_op_t     i_op,
   input  logic [1:0]  i_lane,    // byte address bits [1:0]
   input  logic [31:0] i_wdata,   // store data from the request
   input  logic [31:0] i_old,     // word read back before a sub-word store
   input  logic [31:0] i_spo,     // current DRAM read data
   output logic [31:0] o_merged,  // word to write
   output logic [31:0] o_load     // extended load result
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic        w_sign;

   // Store merge: replace only the addressed lane of the old word
   always_comb begin
      // NOTE: default every always_comb output first so no path infers a latch.
      o_merged = i_old;
      if (is_word(i_op.size)) begin
         o_merged = i_wdata;
      end else if (i_op.size == MEM_H) begin
         if (i_lane[1]) o_merged[31:16] = i_wdata[15:0];
         else           o_merged[15:0]  = i_wdata[15:0];
      end else begin
         case (i_lane)
            2'd0:    o_merged[7:0]   = i_wdata[7:0];
            2'd1:    o_merged[15:8]  = i_wdata[7:0];
            2'd2:    o_merged[23:16] = i_wdata[7:0];
            default: o_merged[31:24] = i_wdata[7:0];
         endcase
      end
   end

   // Load extraction: select the lane, then sign- or zero-extend
   always_comb begin
      case (i_lane)
         2'd0:    w_byte = i_spo[7:0];
         2'd1:    w_byte = i_spo[15:8];
         2'd2:    w_byte = i_spo[23:16];
         default: w_byte = i_spo[31:24];
      endcase
      w_half = i_lane[1] ? i_spo[31:16] : i_spo[15:0];
      w_sign = 1'b0;
      o_load = i_spo;
      if (!is_word(i_op.size)) begin
         if (i_op.size == MEM_H) begin
            w_sign = w_half[15] & ~i_op.uns;
            o_load = {{16{w_sign}}, w_half};
         end else begin
            w_sign = w_byte[7] & ~i_op.uns;
            o_load = {{24{w_sign}}, w_byte};
         end
      end
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl -- one-outstanding-request load/store controller for an
// asynchronous-read DRAM. Sub-word stores are read-modify-write.
// Define MEM_MISALIGN_CHECK_EN to add resp_err and reject misaligned H/W accesses.
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int ADDR_W = mem_pkg::ADDR_W
)(
   input  logic                clk,
   input  logic                rst_n,
   mem_access_ctrl_if.slave    bus,
   output logic [ADDR_W-1:0]   mem_a,
   output logic                mem_we,
   output logic [31:0]         mem_d,
   input  logic [31:0]         mem_spo
);

   state_e      r_state;
   mem_op_t     r_op;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_old;
   logic [31:0] r_rdata;
   logic        r_err;

   mem_op_t     w_req_op;
   logic        w_misalign;
   logic [31:0] w_merged;
   logic [31:0] w_load;
   logic        w_busy;
   logic        w_unused_addr;

   assign w_req_op = mem_op_t'(bus.req_op);

`ifdef MEM_MISALIGN_CHECK_EN
   // Misaligned when a halfword sits on an odd byte or a word is off a word boundary
   assign w_misalign = (is_word(w_req_op.size) && (bus.req_addr[1:0] != 2'd0)) ||
                       ((w_req_op.size == MEM_H) && bus.req_addr[0]);
`else
   assign w_misalign = 1'b0;
`endif

   mem_lane_align u_lane_align (
      .i_op     (r_op),
      .i_lane   (r_addr[1:0]),
      .i_wdata  (r_wdata),
      .i_old    (r_old),
      .i_spo    (mem_spo),
      .o_merged (w_merged),
      .o_load   (w_load)
   );

   // Request FSM: accept, optional read, optional write, hold response
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_op    <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_old   <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  r_op    <= w_req_op;
                  r_we    <= bus.req_we;
                  r_addr  <= bus.req_addr;
                  r_wdata <= bus.req_wdata;
                  r_rdata <= '0;
                  r_err   <= 1'b0;
                  if (w_misalign) begin
                     r_err   <= 1'b1;
                     r_state <= ST_RESP;
                  end else if (bus.req_we && is_word(w_req_op.size)) begin
                     r_state <= ST_WRITE;
                  end else begin
                     r_state <= ST_READ;
                  end
               end
            end
            ST_READ: begin
               if (r_we) begin
                  r_old   <= mem_spo;
                  r_state <= ST_WRITE;
               end else begin
                  r_rdata <= w_load;
                  r_state <= ST_RESP;
               end
            end
            ST_WRITE: r_state <= ST_RESP;
            ST_RESP: begin
               if (bus.resp_ready) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Outputs decoded from state; DRAM signals are zero outside READ/WRITE
   assign w_busy         = (r_state == ST_READ) || (r_state == ST_WRITE);
   assign bus.req_ready  = (r_state == ST_IDLE);
   assign bus.resp_valid = (r_state == ST_RESP);
   assign bus.resp_rdata = (r_state == ST_RESP) ? r_rdata : 32'd0;
   assign mem_a          = w_busy ? r_addr[ADDR_W+1:2] : '0;
   assign mem_we         = (r_state == ST_WRITE);
   assign mem_d          = (r_state == ST_WRITE) ? w_merged : 32'd0;

`ifdef MEM_MISALIGN_CHECK_EN
   assign bus.resp_err   = (r_state == ST_RESP) && r_err;
`endif

   // Address bits above the DRAM range are intentionally ignored
   assign w_unused_addr  = ^{r_addr[31:ADDR_W+2], r_err};

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl -- directed self-checking bench for mem_access_ctrl.
// Models the asynchronous-read DRAM; misalignment cases run when MEM_MISALIGN_CHECK_EN is defined.
module tb_mem_access_ctrl;

   localparam int ADDR_W = 14;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [ADDR_W-1:0] mem_a;
   logic              mem_we;
   logic [31:0]       mem_d;
   logic [31:0]       mem_spo;

   int n_cmp = 0;
   int n_err = 0;
   int we_cnt = 0;

   logic [31:0] dram [0:(1<<ADDR_W)-1];

   mem_access_ctrl_if bus ();

   mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .mem_a   (mem_a),
      .mem_we  (mem_we),
      .mem_d   (mem_d),
      .mem_spo (mem_spo)
   );

   always #5 clk = ~clk;

   // DRAM model: asynchronous read, synchronous write; counts write cycles
   assign mem_spo = dram[mem_a];
   always @(posedge clk) begin
      if (mem_we) begin
         dram[mem_a] <= mem_d;
         we_cnt      <= we_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Wait for req_ready, present one request for one cycle; returns just after the accept edge
   task automatic send(input string tag, input logic we, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wdata);
      int n = 0;
      while (bus.req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_rdy"}, {31'd0, bus.req_ready}, 32'd1);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_op    = op;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   // Cycles from accept until resp_valid, bounded
   task automatic wait_resp(output int lat);
      lat = 1;
      while (bus.resp_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic txn(input string tag, input logic we, input logic [2:0] op,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input int exp_lat, input logic [31:0] exp_rd,
                      input int exp_wes, input logic exp_err);
      int lat;
      int w0;
      send(tag, we, op, addr, wdata);
      w0 = we_cnt;
      wait_resp(lat);
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_rdata"}, bus.resp_rdata, exp_rd);
`ifdef MEM_MISALIGN_CHECK_EN
      check({tag, "_err"}, {31'd0, bus.resp_err}, {31'd0, exp_err});
`else
      if (exp_err) check({tag, "_err_unexpected"}, 32'd0, 32'd1);
`endif
      check({tag, "_wes"}, we_cnt - w0, exp_wes);
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int w0;
      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_op     = 3'd0;
      bus.req_addr   = 32'd0;
      bus.req_wdata  = 32'd0;
      bus.resp_ready = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      check("rst_resp_rdata", bus.resp_rdata, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_mem_a", {18'd0, mem_a}, 32'd0);
      check("rst_mem_d", mem_d, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

      // Word store then signed word load
      txn("st_w_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1, 1'b0);
      check("mem_w4", dram[4], 32'hDEADBEEF);
      txn("ld_w_10", 1'b0, 3'b010, 32'h10, 32'h0, 2, 32'hDEADBEEF, 0, 1'b0);

      // Byte store into 0x11223344, then signed/unsigned byte loads
      txn("st_w_20", 1'b1, 3'b010, 32'h20, 32'h11223344, 2, 32'h0, 1, 1'b0);
      txn("st_b_22", 1'b1, 3'b000, 32'h22, 32'h000000AA, 3, 32'h0, 1, 1'b0);
      check("mem_w8", dram[8], 32'h11AA3344);
      txn("ld_bs_22", 1'b0, 3'b000, 32'h22, 32'h0, 2, 32'hFFFFFFAA, 0, 1'b0);
      txn("ld_bu_22", 1'b0, 3'b100, 32'h22, 32'h0, 2, 32'h000000AA, 0, 1'b0);

      // Halfword store to the upper lane of word 9
      txn("st_w_24", 1'b1, 3'b010, 32'h24, 32'h11AA3344, 2, 32'h0, 1, 1'b0);
      txn("st_h_26", 1'b1, 3'b001, 32'h26, 32'hCAFE8001, 3, 32'h0, 1, 1'b0);
      check("mem_w9", dram[9], 32'h80013344);
      txn("ld_hs_26", 1'b0, 3'b001, 32'h26, 32'h0, 2, 32'hFFFF8001, 0, 1'b0);
      txn("ld_hu_24", 1'b0, 3'b101, 32'h24, 32'h0, 2, 32'h00003344, 0, 1'b0);
      txn("ld_bs_24", 1'b0, 3'b000, 32'h24, 32'h0, 2, 32'h00000044, 0, 1'b0);
      txn("ld_bs_27", 1'b0, 3'b000, 32'h27, 32'h0, 2, 32'hFFFFFF80, 0, 1'b0);
      txn("ld_sz3_24", 1'b0, 3'b011, 32'h24, 32'h0, 2, 32'h80013344, 0, 1'b0);

      // Response held off for 5 cycles
      send("hold", 1'b0, 3'b010, 32'h10, 32'h0);
      wait_resp(lat);
      check("hold_lat", lat, 2);
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", {31'd0, bus.resp_valid}, 32'd1);
         check("hold_rdata", bus.resp_rdata, 32'hDEADBEEF);
         check("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
         @(negedge clk);
      end
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      check("hold_release", {31'd0, bus.resp_valid}, 32'd0);

      // Reset asserted in READ of a byte store
      w0 = we_cnt;
      send("rst_mid", 1'b1, 3'b000, 32'h10, 32'h00000055);
      check("rst_mid_mem_a", {18'd0, mem_a}, 32'd4);
      rst_n = 1'b0;
      #1;
      check("rst_mid_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_mid_mem_a0", {18'd0, mem_a}, 32'd0);
      check("rst_mid_mem_d", mem_d, 32'd0);
      check("rst_mid_valid", {31'd0, bus.resp_valid}, 32'd0);
      check("rst_mid_rdata", bus.resp_rdata, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_mid_no_resp", {31'd0, bus.resp_valid}, 32'd0);
      check("rst_mid_ready", {31'd0, bus.req_ready}, 32'd1);
      check("rst_mid_no_write", we_cnt - w0, 32'd0);
      check("rst_mid_mem_w4", dram[4], 32'hDEADBEEF);
      txn("after_rst", 1'b0, 3'b010, 32'h10, 32'h0, 2, 32'hDEADBEEF, 0, 1'b0);

`ifdef MEM_MISALIGN_CHECK_EN
      // Misaligned accesses are rejected without touching memory
      txn("mis_ld_w_21", 1'b0, 3'b010, 32'h21, 32'h0, 1, 32'h0, 0, 1'b1);
      txn("mis_st_w_21", 1'b1, 3'b010, 32'h21, 32'h12345678, 1, 32'h0, 0, 1'b1);
      txn("mis_st_h_25", 1'b1, 3'b001, 32'h25, 32'h00001234, 1, 32'h0, 0, 1'b1);
      check("mis_mem_w8", dram[8], 32'h11AA3344);
      check("mis_mem_w9", dram[9], 32'h80013344);
      txn("ali_ld_h_26", 1'b0, 3'b101, 32'h26, 32'h0, 2, 32'h00008001, 0, 1'b0);
`else
      // Misaligned low bits are ignored
      txn("ld_w_21", 1'b0, 3'b010, 32'h21, 32'h0, 2, 32'h11AA3344, 0, 1'b0);
      txn("ld_hu_27", 1'b0, 3'b101, 32'h27, 32'h0, 2, 32'h00008001, 0, 1'b0);
      txn("st_w_13", 1'b1, 3'b010, 32'h13, 32'h01020304, 2, 32'h0, 1, 1'b0);
      check("mem_w4_unal", dram[4], 32'h01020304);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
